// File: rtl/mux_result_skid_buffer.sv
// -----------------------------------------------------------------------------
// mux_result_skid_buffer
//
// Two-entry registered skid buffer placed directly after the 32-bit 2:1
// operand mux. It captures the mux result under a valid/ready handshake and
// presents it with a registered output at full throughput. Because in_ready is
// a register, there is no combinational path from out_ready back into the
// mux-select logic.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   in_data    - mux result (WIDTH bits)
//   in_valid   - in_data is valid this cycle
//   in_ready   - buffer can accept (registered)
//   out_data   - head-of-buffer data (registered)
//   out_valid  - out_data is valid (registered)
//   out_ready  - consumer accepts out_data
//   count      - occupancy, 0..2 (registered)
//   xfer_count - number of output transfers, modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module mux_result_skid_buffer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           count,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r;
    logic [WIDTH-1:0]       main_r;
    logic [WIDTH-1:0]       skid_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [1:0]             count_r;
    logic [CNT_WIDTH-1:0]   xfer_count_r;

    logic                   accept_s;
    logic                   emit_s;

    // Handshake events; both qualify only on registered state.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        emit_s   = out_valid_r && out_ready;
    end

    // Buffer FSM: state, storage and all handshake outputs are updated together
    // so that in_ready/out_valid/count are registered and always consistent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            main_r       <= {WIDTH{1'b0}};
            skid_r       <= {WIDTH{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            count_r      <= 2'd0;
            xfer_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (emit_s) begin
                xfer_count_r <= xfer_count_r + CNT_ONE;
            end else begin
                xfer_count_r <= xfer_count_r;
            end

            case (state_r)
                ST_EMPTY: begin
                    // out_valid is low here, so out_ready has no effect.
                    if (accept_s) begin
                        main_r      <= in_data;
                        state_r     <= ST_BUSY;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        count_r     <= 2'd1;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end

                ST_BUSY: begin
                    if (accept_s && emit_s) begin
                        // Head leaves while the new word takes its place.
                        main_r      <= in_data;
                        state_r     <= ST_BUSY;
                    end else if (accept_s) begin
                        // Consumer stalled: park the word in the skid slot
                        // and close the input on the next cycle.
                        skid_r      <= in_data;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b0;
                        count_r     <= 2'd2;
                    end else if (emit_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        count_r     <= 2'd0;
                    end else begin
                        state_r     <= ST_BUSY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low, so only an emit can change state.
                    if (emit_s) begin
                        main_r      <= skid_r;
                        state_r     <= ST_BUSY;
                        in_ready_r  <= 1'b1;
                        count_r     <= 2'd1;
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean empty buffer.
                    state_r     <= ST_EMPTY;
                    main_r      <= {WIDTH{1'b0}};
                    skid_r      <= {WIDTH{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    count_r     <= 2'd0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        in_ready   = in_ready_r;
        out_valid  = out_valid_r;
        out_data   = main_r;
        count      = count_r;
        xfer_count = xfer_count_r;
    end

endmodule

// File: tb/tb_mux_result_skid_buffer.sv
module tb_mux_result_skid_buffer;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 4;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           count;
    logic [CNT_WIDTH-1:0] xfer_count;

    // Upstream 2:1 mux model feeding in_data.
    logic                 sel;
    logic [WIDTH-1:0]     data0;
    logic [WIDTH-1:0]     data1;

    int vectors;
    int miscompares;

    mux_result_skid_buffer #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then move #1 past it before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0000_0000;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (count !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        vectors++;
        if (xfer_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_xfer_count: got %0d expected 0", xfer_count);
        end
        vectors++;
        if (out_data !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h expected 00000000", out_data);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        sel       = 1'b0;
        data0     = 32'h1234_5678;
        data1     = 32'hCAFE_F00D;
        in_data   = sel ? data1 : data0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL single_out: got valid=%b data=%h expected valid=1 data=12345678",
                     out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL single_empty: got valid=%b count=%0d expected valid=0 count=0",
                     out_valid, count);
        end
        vectors++;
        if (xfer_count !== 4'd1) begin
            miscompares++;
            $display("FAIL single_xfer: got %0d expected 1", xfer_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1111_2222 + i;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== (32'h1111_2222 + i) ||
                count !== 2'd1 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_word%0d: got valid=%b data=%h count=%0d rdy=%b expected 1 %h 1 1",
                         i, out_valid, out_data, count, in_ready, 32'h1111_2222 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd8) begin
            miscompares++;
            $display("FAIL stream_end: got valid=%b xfer=%0d expected valid=0 xfer=8",
                     out_valid, xfer_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111_2222;
        tick();
        in_data   = 32'h3333_4444;
        tick();
        vectors++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL bp_full: got count=%0d rdy=%b data=%h expected 2 0 11112222",
                     count, in_ready, out_data);
        end
        in_data = 32'h5555_6666;
        tick();
        tick();
        vectors++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL bp_hold: got count=%0d rdy=%b data=%h expected 2 0 11112222",
                     count, in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_data !== 32'h3333_4444 || count !== 2'd1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second: got data=%h count=%0d rdy=%b expected 33334444 1 1",
                     out_data, count, in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_data !== 32'h5555_6666 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_third: got data=%h valid=%b expected 55556666 1",
                     out_data, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd3) begin
            miscompares++;
            $display("FAIL bp_drain: got valid=%b xfer=%0d expected 0 3", out_valid, xfer_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        tick();
        out_ready = 1'b1;
        in_data   = 32'h5A5A_0002;
        tick();
        in_valid  = 1'b0;
        vectors++;
        if (count !== 2'd1 || out_data !== 32'h5A5A_0002 || xfer_count !== 4'd1) begin
            miscompares++;
            $display("FAIL simul_busy: got count=%0d data=%h xfer=%0d expected 1 5a5a0002 1",
                     count, out_data, xfer_count);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd2) begin
            miscompares++;
            $display("FAIL simul_drain: got valid=%b xfer=%0d expected 0 2", out_valid, xfer_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0100 + i;
            tick();
        end
        in_valid = 1'b0;
        // 17 accepts so far, 16 emits: counter has just wrapped to zero.
        vectors++;
        if (xfer_count !== 4'd0 || out_data !== 32'h0000_0110) begin
            miscompares++;
            $display("FAIL wrap_16: got xfer=%0d data=%h expected 0 00000110",
                     xfer_count, out_data);
        end
        tick();
        vectors++;
        if (xfer_count !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_17: got xfer=%0d expected 1", xfer_count);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0BAD_0001;
        tick();
        in_data   = 32'h0BAD_0002;
        tick();
        vectors++;
        if (count !== 2'd2) begin
            miscompares++;
            $display("FAIL rstfull_pre: got count=%0d expected 2", count);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h0BAD_0003;
        tick();
        reset     = 1'b0;
        vectors++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 32'h0000_0000 || xfer_count !== 4'd0) begin
            miscompares++;
            $display("FAIL rstfull_empty: got count=%0d valid=%b rdy=%b data=%h xfer=%0d expected 0 0 1 0 0",
                     count, out_valid, in_ready, out_data, xfer_count);
        end
        // Unknown data with in_valid low must not reach the outputs.
        in_valid = 1'b0;
        in_data  = 'x;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL x_block: got valid=%b data=%h expected 0 00000000", out_valid, out_data);
        end
        in_valid = 1'b1;
        in_data  = 32'h8765_4321;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h8765_4321) begin
            miscompares++;
            $display("FAIL rstfull_word: got valid=%b data=%h expected 1 87654321",
                     out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd1) begin
            miscompares++;
            $display("FAIL rstfull_alone: got valid=%b xfer=%0d expected 0 1", out_valid, xfer_count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = 32'h0000_0000;
        sel         = 1'b0;
        data0       = 32'h0000_0000;
        data1       = 32'h0000_0000;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
